// File: rtl/axi_lite_slave_conn_buf_pkg.sv
// Shared AXI4-Lite request/response structs, buffer-mask bit positions and
// the saturating outstanding-counter update used by the connector.
package axi_lite_slave_conn_buf_pkg;

    localparam int unsigned AXIL_ADDR_W = 64;
    localparam int unsigned AXIL_DATA_W = 64;
    localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

    localparam int unsigned BUF_AW = 0;
    localparam int unsigned BUF_W  = 1;
    localparam int unsigned BUF_B  = 2;
    localparam int unsigned BUF_AR = 3;
    localparam int unsigned BUF_R  = 4;

    typedef struct packed {
        logic [AXIL_ADDR_W-1:0] aw_addr;
        logic [2:0]             aw_prot;
        logic                   aw_valid;
        logic [AXIL_DATA_W-1:0] w_data;
        logic [AXIL_STRB_W-1:0] w_strb;
        logic                   w_valid;
        logic                   b_ready;
        logic [AXIL_ADDR_W-1:0] ar_addr;
        logic [2:0]             ar_prot;
        logic                   ar_valid;
        logic                   r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic                   aw_ready;
        logic                   w_ready;
        logic [1:0]             b_resp;
        logic                   b_valid;
        logic                   ar_ready;
        logic [AXIL_DATA_W-1:0] r_data;
        logic [1:0]             r_resp;
        logic                   r_valid;
    } axi_lite_rsp_t;

    // A decrement at zero saturates; the caller flags it as an error.
    function automatic logic [7:0] cnt_next(input logic [7:0] cnt,
                                            input logic       inc,
                                            input logic       dec);
        logic [7:0] nxt;
        case ({inc, dec})
            2'b10:   nxt = cnt + 8'd1;
            2'b01:   nxt = (cnt != 8'd0) ? (cnt - 8'd1) : 8'd0;
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/axi_lite_slave_conn_buf_chan_fifo.sv
// Generic valid/ready FIFO without fall-through; ready and valid are held
// low while the synchronous reset is asserted.
module axi_lite_chan_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;

    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign empty_s   = (count_r == CNT_W'(0));
    assign in_ready  = !full_s && !rst_i;
    assign out_valid = !empty_s && !rst_i;
    assign out_data  = rst_i ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Storage, pointers (natural power-of-two wrap) and occupancy count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= in_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/axi_lite_slave_conn_buf.sv
// AXI4-Lite slave connector: flat s_axil ports to req/rsp structs with an
// optional FIFO per channel and outstanding-transaction throttling on AW/AR.
module axi_lite_slave_conn_buf
    import axi_lite_slave_conn_buf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [4:0]  BUF_MASK   = 5'b11111,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned MAX_WR_OUT = 4,
    parameter int unsigned MAX_RD_OUT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output axi_lite_req_t         axi_lite_req_o,
    input  axi_lite_rsp_t         axi_lite_rsp_i,
    output logic [7:0]            wr_outstanding_o,
    output logic [7:0]            rd_outstanding_o,
    output logic                  resp_err_o
);

    localparam int unsigned AW_W = ADDR_WIDTH + 3;
    localparam int unsigned W_W  = DATA_WIDTH + STRB_WIDTH;
    localparam int unsigned B_W  = 2;
    localparam int unsigned R_W  = DATA_WIDTH + 2;

    logic [7:0] wr_cnt_r;
    logic [7:0] rd_cnt_r;
    logic       resp_err_r;
    logic       aw_block_s;
    logic       ar_block_s;

    logic [AW_W-1:0] aw_in_data_s,  aw_out_data_s;
    logic            aw_in_valid_s, aw_in_ready_s, aw_out_valid_s;
    logic [W_W-1:0]  w_in_data_s,   w_out_data_s;
    logic            w_in_ready_s,  w_out_valid_s;
    logic [B_W-1:0]  b_out_data_s;
    logic            b_in_ready_s,  b_out_valid_s;
    logic [AW_W-1:0] ar_in_data_s,  ar_out_data_s;
    logic            ar_in_valid_s, ar_in_ready_s, ar_out_valid_s;
    logic [R_W-1:0]  r_in_data_s,   r_out_data_s;
    logic            r_in_ready_s,  r_out_valid_s;

    logic aw_hs_s, b_hs_s, ar_hs_s, r_hs_s;

    // Throttle looks at the registered count only.
    assign aw_block_s = (wr_cnt_r == 8'(MAX_WR_OUT));
    assign ar_block_s = (rd_cnt_r == 8'(MAX_RD_OUT));

    assign aw_in_data_s  = {s_axil_awaddr, s_axil_awprot};
    assign aw_in_valid_s = s_axil_awvalid && !aw_block_s;
    assign w_in_data_s   = {s_axil_wdata, s_axil_wstrb};
    assign ar_in_data_s  = {s_axil_araddr, s_axil_arprot};
    assign ar_in_valid_s = s_axil_arvalid && !ar_block_s;
    assign r_in_data_s   = {DATA_WIDTH'(axi_lite_rsp_i.r_data), axi_lite_rsp_i.r_resp};

    assign s_axil_awready = aw_in_ready_s && !aw_block_s;
    assign s_axil_wready  = w_in_ready_s;
    assign s_axil_bresp   = b_out_data_s;
    assign s_axil_bvalid  = b_out_valid_s;
    assign s_axil_arready = ar_in_ready_s && !ar_block_s;
    assign s_axil_rdata   = r_out_data_s[R_W-1:2];
    assign s_axil_rresp   = r_out_data_s[1:0];
    assign s_axil_rvalid  = r_out_valid_s;

    generate
        if (BUF_MASK[BUF_AW]) begin : g_aw_buf
            axi_lite_chan_fifo #(.WIDTH(AW_W), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
                .clk_i(clk_i), .rst_i(rst_i),
                .in_data(aw_in_data_s), .in_valid(aw_in_valid_s), .in_ready(aw_in_ready_s),
                .out_data(aw_out_data_s), .out_valid(aw_out_valid_s),
                .out_ready(axi_lite_rsp_i.aw_ready));
        end else begin : g_aw_wire
            assign aw_out_data_s  = aw_in_data_s;
            assign aw_out_valid_s = aw_in_valid_s && !rst_i;
            assign aw_in_ready_s  = axi_lite_rsp_i.aw_ready && !rst_i;
        end

        if (BUF_MASK[BUF_W]) begin : g_w_buf
            axi_lite_chan_fifo #(.WIDTH(W_W), .DEPTH(FIFO_DEPTH)) u_w_fifo (
                .clk_i(clk_i), .rst_i(rst_i),
                .in_data(w_in_data_s), .in_valid(s_axil_wvalid), .in_ready(w_in_ready_s),
                .out_data(w_out_data_s), .out_valid(w_out_valid_s),
                .out_ready(axi_lite_rsp_i.w_ready));
        end else begin : g_w_wire
            assign w_out_data_s  = w_in_data_s;
            assign w_out_valid_s = s_axil_wvalid && !rst_i;
            assign w_in_ready_s  = axi_lite_rsp_i.w_ready && !rst_i;
        end

        if (BUF_MASK[BUF_B]) begin : g_b_buf
            axi_lite_chan_fifo #(.WIDTH(B_W), .DEPTH(FIFO_DEPTH)) u_b_fifo (
                .clk_i(clk_i), .rst_i(rst_i),
                .in_data(axi_lite_rsp_i.b_resp), .in_valid(axi_lite_rsp_i.b_valid),
                .in_ready(b_in_ready_s),
                .out_data(b_out_data_s), .out_valid(b_out_valid_s),
                .out_ready(s_axil_bready));
        end else begin : g_b_wire
            assign b_out_data_s  = axi_lite_rsp_i.b_resp;
            assign b_out_valid_s = axi_lite_rsp_i.b_valid && !rst_i;
            assign b_in_ready_s  = s_axil_bready && !rst_i;
        end

        if (BUF_MASK[BUF_AR]) begin : g_ar_buf
            axi_lite_chan_fifo #(.WIDTH(AW_W), .DEPTH(FIFO_DEPTH)) u_ar_fifo (
                .clk_i(clk_i), .rst_i(rst_i),
                .in_data(ar_in_data_s), .in_valid(ar_in_valid_s), .in_ready(ar_in_ready_s),
                .out_data(ar_out_data_s), .out_valid(ar_out_valid_s),
                .out_ready(axi_lite_rsp_i.ar_ready));
        end else begin : g_ar_wire
            assign ar_out_data_s  = ar_in_data_s;
            assign ar_out_valid_s = ar_in_valid_s && !rst_i;
            assign ar_in_ready_s  = axi_lite_rsp_i.ar_ready && !rst_i;
        end

        if (BUF_MASK[BUF_R]) begin : g_r_buf
            axi_lite_chan_fifo #(.WIDTH(R_W), .DEPTH(FIFO_DEPTH)) u_r_fifo (
                .clk_i(clk_i), .rst_i(rst_i),
                .in_data(r_in_data_s), .in_valid(axi_lite_rsp_i.r_valid),
                .in_ready(r_in_ready_s),
                .out_data(r_out_data_s), .out_valid(r_out_valid_s),
                .out_ready(s_axil_rready));
        end else begin : g_r_wire
            assign r_out_data_s  = r_in_data_s;
            assign r_out_valid_s = axi_lite_rsp_i.r_valid && !rst_i;
            assign r_in_ready_s  = s_axil_rready && !rst_i;
        end
    endgenerate

    assign aw_hs_s = s_axil_awvalid && s_axil_awready;
    assign b_hs_s  = s_axil_bvalid && s_axil_bready;
    assign ar_hs_s = s_axil_arvalid && s_axil_arready;
    assign r_hs_s  = s_axil_rvalid && s_axil_rready;

    // Outstanding counters, measured at the s_axil side.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt_r <= 8'd0;
            rd_cnt_r <= 8'd0;
        end else begin
            wr_cnt_r <= cnt_next(wr_cnt_r, aw_hs_s, b_hs_s);
            rd_cnt_r <= cnt_next(rd_cnt_r, ar_hs_s, r_hs_s);
        end
    end

    // Sticky flag for a response delivered with nothing outstanding.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_err_r <= 1'b0;
        end else if ((b_hs_s && (wr_cnt_r == 8'd0)) || (r_hs_s && (rd_cnt_r == 8'd0))) begin
            resp_err_r <= 1'b1;
        end else begin
            resp_err_r <= resp_err_r;
        end
    end

    assign wr_outstanding_o = wr_cnt_r;
    assign rd_outstanding_o = rd_cnt_r;
    assign resp_err_o       = resp_err_r;

    // Map channel outputs onto the request struct.
    always_comb begin
        axi_lite_req_o          = '0;
        axi_lite_req_o.aw_addr  = AXIL_ADDR_W'(aw_out_data_s[AW_W-1:3]);
        axi_lite_req_o.aw_prot  = aw_out_data_s[2:0];
        axi_lite_req_o.aw_valid = aw_out_valid_s;
        axi_lite_req_o.w_data   = AXIL_DATA_W'(w_out_data_s[W_W-1:STRB_WIDTH]);
        axi_lite_req_o.w_strb   = AXIL_STRB_W'(w_out_data_s[STRB_WIDTH-1:0]);
        axi_lite_req_o.w_valid  = w_out_valid_s;
        axi_lite_req_o.b_ready  = b_in_ready_s;
        axi_lite_req_o.ar_addr  = AXIL_ADDR_W'(ar_out_data_s[AW_W-1:3]);
        axi_lite_req_o.ar_prot  = ar_out_data_s[2:0];
        axi_lite_req_o.ar_valid = ar_out_valid_s;
        axi_lite_req_o.r_ready  = r_in_ready_s;
    end

endmodule

// File: tb/tb_axi_lite_slave_conn_buf.sv
// Directed bench: a fully buffered instance and a BUF_MASK=0 pass-through
// instance sharing clock and reset.
module tb_axi_lite_slave_conn_buf;
    import axi_lite_slave_conn_buf_pkg::*;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Buffered instance signals
    logic [63:0] a_awaddr, a_wdata, a_araddr, a_rdata;
    logic [2:0]  a_awprot, a_arprot;
    logic [7:0]  a_wstrb, a_wr_out, a_rd_out;
    logic [1:0]  a_bresp, a_rresp;
    logic a_awvalid, a_awready, a_wvalid, a_wready, a_bvalid, a_bready;
    logic a_arvalid, a_arready, a_rvalid, a_rready, a_err;
    axi_lite_req_t req_a;
    axi_lite_rsp_t rsp_a;

    // Pass-through instance signals
    logic [63:0] p_awaddr, p_wdata, p_araddr, p_rdata;
    logic [2:0]  p_awprot, p_arprot;
    logic [7:0]  p_wstrb, p_wr_out, p_rd_out;
    logic [1:0]  p_bresp, p_rresp;
    logic p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready;
    logic p_arvalid, p_arready, p_rvalid, p_rready, p_err;
    axi_lite_req_t req_p;
    axi_lite_rsp_t rsp_p;

    axi_lite_slave_conn_buf u_dut_a (
        .clk_i(clk), .rst_i(rst_i),
        .s_axil_awaddr(a_awaddr), .s_axil_awprot(a_awprot), .s_axil_awvalid(a_awvalid),
        .s_axil_awready(a_awready),
        .s_axil_wdata(a_wdata), .s_axil_wstrb(a_wstrb), .s_axil_wvalid(a_wvalid),
        .s_axil_wready(a_wready),
        .s_axil_bresp(a_bresp), .s_axil_bvalid(a_bvalid), .s_axil_bready(a_bready),
        .s_axil_araddr(a_araddr), .s_axil_arprot(a_arprot), .s_axil_arvalid(a_arvalid),
        .s_axil_arready(a_arready),
        .s_axil_rdata(a_rdata), .s_axil_rresp(a_rresp), .s_axil_rvalid(a_rvalid),
        .s_axil_rready(a_rready),
        .axi_lite_req_o(req_a), .axi_lite_rsp_i(rsp_a),
        .wr_outstanding_o(a_wr_out), .rd_outstanding_o(a_rd_out), .resp_err_o(a_err));

    axi_lite_slave_conn_buf #(.BUF_MASK(5'b00000)) u_dut_p (
        .clk_i(clk), .rst_i(rst_i),
        .s_axil_awaddr(p_awaddr), .s_axil_awprot(p_awprot), .s_axil_awvalid(p_awvalid),
        .s_axil_awready(p_awready),
        .s_axil_wdata(p_wdata), .s_axil_wstrb(p_wstrb), .s_axil_wvalid(p_wvalid),
        .s_axil_wready(p_wready),
        .s_axil_bresp(p_bresp), .s_axil_bvalid(p_bvalid), .s_axil_bready(p_bready),
        .s_axil_araddr(p_araddr), .s_axil_arprot(p_arprot), .s_axil_arvalid(p_arvalid),
        .s_axil_arready(p_arready),
        .s_axil_rdata(p_rdata), .s_axil_rresp(p_rresp), .s_axil_rvalid(p_rvalid),
        .s_axil_rready(p_rready),
        .axi_lite_req_o(req_p), .axi_lite_rsp_i(rsp_p),
        .wr_outstanding_o(p_wr_out), .rd_outstanding_o(p_rd_out), .resp_err_o(p_err));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int  pw, pr;
    logic exp_awr, exp_arr;

    initial begin
        rst_i = 1'b1;
        a_awaddr = 64'd0; a_awprot = 3'd0; a_awvalid = 1'b0;
        a_wdata = 64'd0; a_wstrb = 8'd0; a_wvalid = 1'b0; a_bready = 1'b0;
        a_araddr = 64'd0; a_arprot = 3'd0; a_arvalid = 1'b0; a_rready = 1'b0;
        rsp_a = '0;
        p_awaddr = 64'd0; p_awprot = 3'd0; p_awvalid = 1'b0;
        p_wdata = 64'd0; p_wstrb = 8'd0; p_wvalid = 1'b0; p_bready = 1'b0;
        p_araddr = 64'd0; p_arprot = 3'd0; p_arvalid = 1'b0; p_rready = 1'b0;
        rsp_p = '0;
        rsp_p.aw_ready = 1'b1;

        // Reset state: readies/valids gated on both sides
        tick(); tick();
        chk("rst_awready", a_awready, 1'b0);
        chk("rst_wready", a_wready, 1'b0);
        chk("rst_arready", a_arready, 1'b0);
        chk("rst_b_ready", req_a.b_ready, 1'b0);
        chk("rst_bvalid", a_bvalid, 1'b0);
        chk("rst_p_awready", p_awready, 1'b0);
        chk("rst_wr_out", a_wr_out, 8'd0);
        chk("rst_rd_out", a_rd_out, 8'd0);
        chk("rst_err", a_err, 1'b0);
        rst_i = 1'b0;
        #1;
        chk("post_rst_awready", a_awready, 1'b1);
        chk("post_rst_p_awready", p_awready, 1'b1);
        rsp_p.aw_ready = 1'b0;

        // Single write through buffered AW/W/B
        rsp_a.aw_ready = 1'b1; rsp_a.w_ready = 1'b1;
        a_awvalid = 1'b1; a_awaddr = 64'h10; a_awprot = 3'b010;
        a_wvalid = 1'b1; a_wdata = 64'hDEADBEEF; a_wstrb = 8'hFF;
        #1;
        chk("wr_no_fallthru", req_a.aw_valid, 1'b0);
        chk("wr_awready", a_awready, 1'b1);
        tick();
        a_awvalid = 1'b0; a_wvalid = 1'b0;
        #1;
        chk("wr_aw_valid", req_a.aw_valid, 1'b1);
        chk("wr_aw_addr", req_a.aw_addr, 64'h10);
        chk("wr_aw_prot", req_a.aw_prot, 3'b010);
        chk("wr_w_valid", req_a.w_valid, 1'b1);
        chk("wr_w_data", req_a.w_data, 64'hDEADBEEF);
        chk("wr_w_strb", req_a.w_strb, 8'hFF);
        chk("wr_out_1", a_wr_out, 8'd1);
        tick();
        #1;
        chk("wr_aw_drained", req_a.aw_valid, 1'b0);
        rsp_a.b_valid = 1'b1; rsp_a.b_resp = 2'b00; a_bready = 1'b1;
        #1;
        chk("b_no_fallthru", a_bvalid, 1'b0);
        tick();
        rsp_a.b_valid = 1'b0;
        #1;
        chk("b_valid", a_bvalid, 1'b1);
        chk("b_resp", a_bresp, 2'b00);
        tick();
        #1;
        chk("wr_out_0", a_wr_out, 8'd0);

        // Read throttle at MAX_RD_OUT=4 with R held off
        rsp_a.ar_ready = 1'b1; a_arvalid = 1'b1; a_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_araddr = 64'h100 + 64'(i * 8);
            #1;
            chk("thr_arready", a_arready, 1'b1);
            chk("thr_rd_out", a_rd_out, 8'(i));
            tick();
        end
        #1;
        chk("thr_5th_refused", a_arready, 1'b0);
        chk("thr_rd_out_4", a_rd_out, 8'd4);
        rsp_a.r_valid = 1'b1; rsp_a.r_data = 64'h0123456789ABCDEF; rsp_a.r_resp = 2'b00;
        tick();
        rsp_a.r_valid = 1'b0;
        #1;
        chk("thr_rvalid", a_rvalid, 1'b1);
        chk("thr_rdata", a_rdata, 64'h0123456789ABCDEF);
        chk("thr_still_blocked", a_arready, 1'b0);
        tick();
        #1;
        chk("thr_rd_out_3", a_rd_out, 8'd3);
        chk("thr_arready_back", a_arready, 1'b1);
        a_arvalid = 1'b0;

        // W FIFO fills at depth 2, then drains in order
        rsp_a.w_ready = 1'b0;
        a_wvalid = 1'b1; a_wdata = 64'hA1; a_wstrb = 8'h0F;
        #1; chk("full_wready_0", a_wready, 1'b1);
        tick();
        a_wdata = 64'hA2; a_wstrb = 8'hF0;
        #1; chk("full_wready_1", a_wready, 1'b1);
        tick();
        a_wdata = 64'hA3; a_wstrb = 8'hFF;
        #1;
        chk("full_wready_2", a_wready, 1'b0);
        chk("full_head_data", req_a.w_data, 64'hA1);
        chk("full_head_strb", req_a.w_strb, 8'h0F);
        tick();
        rsp_a.w_ready = 1'b1;
        #1; chk("full_no_push_on_pop", a_wready, 1'b0);
        tick();
        #1;
        chk("drain_beat2", req_a.w_data, 64'hA2);
        chk("drain_strb2", req_a.w_strb, 8'hF0);
        chk("drain_wready", a_wready, 1'b1);
        tick();
        a_wvalid = 1'b0;
        #1;
        chk("drain_beat3", req_a.w_data, 64'hA3);
        chk("drain_valid3", req_a.w_valid, 1'b1);
        tick();
        #1; chk("drain_empty", req_a.w_valid, 1'b0);

        // Spurious B with write counter at 0
        rsp_a.b_valid = 1'b1; rsp_a.b_resp = 2'b10; a_bready = 1'b1;
        tick();
        rsp_a.b_valid = 1'b0;
        #1;
        chk("spur_bvalid", a_bvalid, 1'b1);
        chk("spur_bresp", a_bresp, 2'b10);
        chk("spur_err_before", a_err, 1'b0);
        tick();
        #1;
        chk("spur_err", a_err, 1'b1);
        chk("spur_wr_out", a_wr_out, 8'd0);

        // Reset with two W beats queued
        rsp_a.w_ready = 1'b0;
        a_wvalid = 1'b1; a_wdata = 64'hB1;
        tick();
        a_wdata = 64'hB2;
        tick();
        a_wvalid = 1'b0;
        #1; chk("q_w_valid", req_a.w_valid, 1'b1);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_w_valid", req_a.w_valid, 1'b0);
        chk("mid_rst_wready", a_wready, 1'b0);
        chk("mid_rst_w_data", req_a.w_data, 64'h0);
        tick();
        #1;
        chk("mid_rst_rd_out", a_rd_out, 8'd0);
        chk("mid_rst_err", a_err, 1'b0);
        rst_i = 1'b0; rsp_a.w_ready = 1'b1;
        #1;
        chk("after_rst_w_valid", req_a.w_valid, 1'b0);
        chk("after_rst_wready", a_wready, 1'b1);
        a_awvalid = 1'b1; a_awaddr = 64'h20; a_awprot = 3'b000;
        a_wvalid = 1'b1; a_wdata = 64'hCAFE; a_wstrb = 8'hFF;
        tick();
        a_awvalid = 1'b0; a_wvalid = 1'b0;
        #1;
        chk("pr_aw_valid", req_a.aw_valid, 1'b1);
        chk("pr_aw_addr", req_a.aw_addr, 64'h20);
        chk("pr_wr_out", a_wr_out, 8'd1);
        rsp_a.b_valid = 1'b1; rsp_a.b_resp = 2'b00; a_bready = 1'b1;
        tick();
        rsp_a.b_valid = 1'b0;
        #1; chk("pr_bvalid", a_bvalid, 1'b1);
        tick();
        #1;
        chk("pr_wr_out_0", a_wr_out, 8'd0);
        chk("pr_err", a_err, 1'b0);

        // BUF_MASK=0: random traffic, zero-cycle bit-exact pass-through
        pw = 0; pr = 0;
        for (int k = 0; k < 12; k++) begin
            p_awaddr = {$urandom, $urandom}; p_awprot = 3'($urandom);
            p_awvalid = 1'($urandom_range(0, 1));
            p_wdata = {$urandom, $urandom}; p_wstrb = 8'($urandom);
            p_wvalid = 1'($urandom_range(0, 1)); p_bready = 1'($urandom_range(0, 1));
            p_araddr = {$urandom, $urandom}; p_arprot = 3'($urandom);
            p_arvalid = 1'($urandom_range(0, 1)); p_rready = 1'($urandom_range(0, 1));
            rsp_p.aw_ready = 1'($urandom_range(0, 1));
            rsp_p.w_ready = 1'($urandom_range(0, 1));
            rsp_p.b_resp = 2'($urandom); rsp_p.b_valid = 1'($urandom_range(0, 1));
            rsp_p.ar_ready = 1'($urandom_range(0, 1));
            rsp_p.r_data = {$urandom, $urandom}; rsp_p.r_resp = 2'($urandom);
            rsp_p.r_valid = 1'($urandom_range(0, 1));
            #1;
            exp_awr = rsp_p.aw_ready && (pw != 4);
            exp_arr = rsp_p.ar_ready && (pr != 4);
            chk("pt_aw_addr", req_p.aw_addr, p_awaddr);
            chk("pt_aw_prot", req_p.aw_prot, p_awprot);
            chk("pt_aw_valid", req_p.aw_valid, p_awvalid && (pw != 4));
            chk("pt_awready", p_awready, exp_awr);
            chk("pt_w_data", req_p.w_data, p_wdata);
            chk("pt_w_strb", req_p.w_strb, p_wstrb);
            chk("pt_w_valid", req_p.w_valid, p_wvalid);
            chk("pt_wready", p_wready, rsp_p.w_ready);
            chk("pt_bresp", p_bresp, rsp_p.b_resp);
            chk("pt_bvalid", p_bvalid, rsp_p.b_valid);
            chk("pt_b_ready", req_p.b_ready, p_bready);
            chk("pt_ar_addr", req_p.ar_addr, p_araddr);
            chk("pt_ar_prot", req_p.ar_prot, p_arprot);
            chk("pt_ar_valid", req_p.ar_valid, p_arvalid && (pr != 4));
            chk("pt_arready", p_arready, exp_arr);
            chk("pt_rdata", p_rdata, rsp_p.r_data);
            chk("pt_rresp", p_rresp, rsp_p.r_resp);
            chk("pt_rvalid", p_rvalid, rsp_p.r_valid);
            chk("pt_r_ready", req_p.r_ready, p_rready);
            chk("pt_wr_out", p_wr_out, 8'(pw));
            chk("pt_rd_out", p_rd_out, 8'(pr));
            if ((p_awvalid && exp_awr) && !(rsp_p.b_valid && p_bready)) pw++;
            else if (!(p_awvalid && exp_awr) && (rsp_p.b_valid && p_bready) && pw > 0) pw--;
            if ((p_arvalid && exp_arr) && !(rsp_p.r_valid && p_rready)) pr++;
            else if (!(p_arvalid && exp_arr) && (rsp_p.r_valid && p_rready) && pr > 0) pr--;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
